block_row_loader: RTL and testbench

- Upstream feeder for subpixel_interpolation.
- Fetches a BLK_H x BLK_W block of 8-bit integer pixels from a byte-wide, fixed-latency image memory and packs each image row into one BLK_W*PIX_W-bit word.
- Serves the packed rows on in_row, selected by the interpolator's next_row index.
- Holds the interpolator in reset until the whole block is resident.

---
 rtl/block_row_loader_if.sv | 18 +
 rtl/block_row_loader.sv | 149 ++++++++++++++
 tb/tb_block_row_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/block_row_loader_if.sv
// rtl/block_row_loader_if.sv - image memory read bus between block_row_loader and the image memory
//
// Signals:
//   mem_rd_en    read strobe (loader -> memory)
//   mem_addr     read address (loader -> memory)
//   mem_rd_data  read data, valid one cycle after mem_rd_en (memory -> loader)
// Modports: master = loader side, slave = memory side.
interface block_row_loader_if #(
  parameter int ADDR_W = 18,
  parameter int PIX_W  = 8
) ();
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rd_data;

  modport master (output mem_rd_en, output mem_addr, input mem_rd_data);
  modport slave  (input mem_rd_en, input mem_addr, output mem_rd_data);
endinterface

// File: rtl/block_row_loader.sv
// rtl/block_row_loader.sv - fetches a BLK_H x BLK_W pixel block and serves packed rows
//
// Loads a block of pixels from a byte-wide, 1-cycle-latency image memory in raster
// order, packs each row into one BLK_W*PIX_W word and serves it by row index. The
// downstream interpolator is held in reset until the whole block is resident.
//
// Ports:
//   clk           clock
//   rst           asynchronous active-low reset
//   start         begin a block load (accepted in IDLE or READY)
//   base_addr     address of block pixel (0,0), captured with start
//   busy          high while fetching / draining
//   done          one-cycle pulse on entry to READY
//   interp_rst_n  active-low reset for the interpolator, high only in READY
//   mem           image memory read bus (master side)
//   row_idx       row select from the interpolator
//   in_row        packed row, pixel 0 in the LSBs, combinational
//
// Optional: define ROW_EDGE_PAD_EN to replicate the last row for row_idx >= BLK_H;
// otherwise out-of-range rows read as zero.
module block_row_loader #(
  parameter int PIX_W  = 8,
  parameter int BLK_W  = 15,
  parameter int BLK_H  = 15,
  parameter int ADDR_W = 18,
  parameter int STRIDE = 400,
  parameter int IDX_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     interp_rst_n,
  block_row_loader_if.master       mem,
  input  logic [IDX_W-1:0]         row_idx,
  output logic [BLK_W*PIX_W-1:0]   in_row
);

  localparam int ROW_W = BLK_W * PIX_W;
  localparam int R_W   = (BLK_H > 1) ? $clog2(BLK_H) : 1;
  localparam int C_W   = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam logic [R_W-1:0]    LAST_R   = R_W'(BLK_H - 1);
  localparam logic [C_W-1:0]    LAST_C   = C_W'(BLK_W - 1);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_READY} state_t;

  state_t            state_q, state_d;
  logic [R_W-1:0]    r_q, r_d;
  logic [C_W-1:0]    c_q, c_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              done_q;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  // Read request delayed by one cycle so it lines up with the returning data.
  logic              cap_en_q;
  logic [R_W-1:0]    cap_r_q;
  logic [C_W-1:0]    cap_c_q;

  logic [ROW_W-1:0]  row_store_q [BLK_H];

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    c_d          = c_q;
    row_base_d   = row_base_q;
    busy         = 1'b0;
    interp_rst_n = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    case (state_q)
      S_IDLE, S_READY: begin
        interp_rst_n = (state_q == S_READY);
        if (start) begin
          state_d    = S_FETCH;
          row_base_d = base_addr;
          r_d        = '0;
          c_d        = '0;
        end
      end
      S_FETCH: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        // Row base advances by STRIDE per row, so no multiplier; sums wrap at 2^ADDR_W.
        rd_addr = row_base_q + ADDR_W'(c_q);
        if (c_q == LAST_C) begin
          c_d        = '0;
          row_base_d = row_base_q + STRIDE_A;
          if (r_q == LAST_R) begin
            r_d     = '0;
            state_d = S_DRAIN;
          end else begin
            r_d = r_q + 1'b1;
          end
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      r_q        <= '0;
      c_q        <= '0;
      row_base_q <= '0;
      done_q     <= 1'b0;
      cap_en_q   <= 1'b0;
      cap_r_q    <= '0;
      cap_c_q    <= '0;
      for (int i = 0; i < BLK_H; i++) row_store_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      row_base_q <= row_base_d;
      // DRAIN always moves to READY, so this flags exactly the first READY cycle.
      done_q     <= (state_q == S_DRAIN);
      cap_en_q   <= rd_en;
      cap_r_q    <= r_q;
      cap_c_q    <= c_q;
      if (cap_en_q) row_store_q[cap_r_q][cap_c_q*PIX_W +: PIX_W] <= mem.mem_rd_data;
    end
  end

  always_comb begin
    in_row = '0;
    for (int i = 0; i < BLK_H; i++) begin
      if (row_idx == IDX_W'(i)) in_row = row_store_q[i];
    end
`ifdef ROW_EDGE_PAD_EN
    if (row_idx >= IDX_W'(BLK_H)) in_row = row_store_q[BLK_H-1];
`endif
  end

  assign mem.mem_rd_en = rd_en;
  assign mem.mem_addr  = rd_addr;
  assign done          = done_q;

endmodule

// File: tb/tb_block_row_loader.sv
// tb/tb_block_row_loader.sv - self-checking bench for block_row_loader with a behavioural memory/block model
module tb_block_row_loader;

  localparam int ADDR_W = 18;
  localparam int PIX_W  = 8;
  localparam int BLK_W  = 15;
  localparam int BLK_H  = 15;
  localparam int STRIDE = 400;
  localparam int ROW_W  = BLK_W * PIX_W;
  localparam int LOAD_CYC = BLK_W * BLK_H + 1;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;
  logic              interp_rst_n;
  logic [7:0]        row_idx;
  logic [ROW_W-1:0]  in_row;

  block_row_loader_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) mem_if ();

  block_row_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .busy         (busy),
    .done         (done),
    .interp_rst_n (interp_rst_n),
    .mem          (mem_if),
    .row_idx      (row_idx),
    .in_row       (in_row)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0]        seed;
  logic [ADDR_W-1:0] last_base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image content: low address byte scrambled by a per-load seed (seed 0 gives mem[a]=a[7:0]).
  function automatic logic [7:0] pix_at(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ seed;
  endfunction

  function automatic logic [ROW_W-1:0] exp_row(input int r, input logic [ADDR_W-1:0] base);
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] a;
    row = '0;
    for (int c = 0; c < BLK_W; c++) begin
      a = base + ADDR_W'(r * STRIDE + c);
      row[c*PIX_W +: PIX_W] = pix_at(a);
    end
    return row;
  endfunction

  always @(posedge clk) begin
    if (mem_if.mem_rd_en) mem_if.mem_rd_data <= pix_at(mem_if.mem_addr);
  end

  // Activity monitor: totals only grow; tasks work on deltas.
  int   cyc = 0, busy_tot = 0, done_tot = 0, rd_tot = 0, viol_tot = 0;
  int   busy_rise_cyc = 0, done_cyc = 0;
  logic busy_prev = 1'b0;
  logic [ADDR_W-1:0] addr_log [0:8191];

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    busy_prev <= busy;
    if (busy) busy_tot <= busy_tot + 1;
    if (busy && !busy_prev) busy_rise_cyc <= cyc;
    if (done) begin
      done_tot <= done_tot + 1;
      done_cyc <= cyc;
    end
    if ((busy && interp_rst_n) || (mem_if.mem_rd_en && !busy)) viol_tot <= viol_tot + 1;
    if (mem_if.mem_rd_en && rd_tot < 8192) begin
      addr_log[rd_tot] <= mem_if.mem_addr;
      rd_tot <= rd_tot + 1;
    end
  end

  task automatic run_load(input logic [ADDR_W-1:0] base, input bit extra, input string tag,
                          output int first_rd);
    int n, b0, d0, v0, bad, bad_k;
    logic [ADDR_W-1:0] ea, bad_a;
    b0 = busy_tot; d0 = done_tot; v0 = viol_tot; first_rd = rd_tot;
    base_addr = base;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    base_addr = ~base;
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      @(negedge clk); #1;
      n++;
      start = extra && (n == 50 || n == 120);
    end
    start = 1'b0;
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL %s timeout: no done after %0d cycles, required within %0d", tag, n, LOAD_CYC);
    end
    checks++;
    if (busy !== 1'b0 || interp_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL %s done_cycle: busy=%b interp_rst_n=%b, required 0 and 1", tag, busy, interp_rst_n);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || interp_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_hold: done=%b interp_rst_n=%b, required 0 and 1", tag, done, interp_rst_n);
    end
    checks++;
    if (busy_tot - b0 !== LOAD_CYC) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, required %0d", tag, busy_tot - b0, LOAD_CYC);
    end
    checks++;
    if (done_tot - d0 !== 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d, required 1", tag, done_tot - d0);
    end
    checks++;
    if (done_cyc - busy_rise_cyc !== LOAD_CYC) begin
      errors++;
      $display("FAIL %s done_latency: got %0d, required %0d", tag, done_cyc - busy_rise_cyc, LOAD_CYC);
    end
    checks++;
    if (rd_tot - first_rd !== BLK_W * BLK_H) begin
      errors++;
      $display("FAIL %s read_count: got %0d, required %0d", tag, rd_tot - first_rd, BLK_W * BLK_H);
    end
    checks++;
    if (viol_tot !== v0) begin
      errors++;
      $display("FAIL %s interface_during_busy: %0d bad cycles, required 0", tag, viol_tot - v0);
    end
    bad = 0; bad_k = 0; bad_a = '0; ea = '0;
    for (int k = 0; k < BLK_W * BLK_H; k++) begin
      ea = base + ADDR_W'((k / BLK_W) * STRIDE + (k % BLK_W));
      if (addr_log[first_rd + k] !== ea) begin
        if (bad == 0) begin
          bad_k = k;
          bad_a = ea;
        end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s addr_seq: read %0d got %0d, required %0d (%0d bad)", tag, bad_k,
               addr_log[first_rd + bad_k], bad_a, bad);
    end
    last_base = base;
  endtask

  task automatic check_rows(input logic [ADDR_W-1:0] base, input string tag);
    logic [ROW_W-1:0] e;
    for (int r = 0; r < BLK_H; r++) begin
      @(negedge clk);
      row_idx = 8'(r);
      #1;
      e = exp_row(r, base);
      checks++;
      if (in_row !== e) begin
        errors++;
        $display("FAIL %s row%0d: got %h, required %h", tag, r, in_row, e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; base_addr = '0; row_idx = '0; seed = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, interp_rst_n, mem_if.mem_rd_en} !== 4'b0000 || mem_if.mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy/done/irst/rd_en=%b%b%b%b addr=%0d, required 0000 and 0",
               busy, done, interp_rst_n, mem_if.mem_rd_en, mem_if.mem_addr);
    end
    for (int r = 0; r <= BLK_H; r++) begin
      @(negedge clk);
      row_idx = 8'(r);
      #1;
      checks++;
      if (in_row !== '0) begin
        errors++;
        $display("FAIL reset_row%0d: got %h, required 0", r, in_row);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_basic_load();
    int f;
    logic [ROW_W-1:0] row0;
    seed = 8'h00;
    run_load('0, 1'b0, "basic", f);
    row0 = 120'h0e0d0c0b0a09080706050403020100;
    @(negedge clk); row_idx = 8'd0; #1;
    checks++;
    if (in_row !== row0) begin
      errors++;
      $display("FAIL basic row0_literal: got %h, required %h", in_row, row0);
    end
    @(negedge clk); row_idx = 8'd1; #1;
    checks++;
    if (in_row[7:0] !== 8'h90 || in_row[119:112] !== 8'h9e) begin
      errors++;
      $display("FAIL basic row1_edges: got p0=%h p14=%h, required 90 and 9e", in_row[7:0], in_row[119:112]);
    end
    check_rows('0, "basic");
  endtask

  task automatic test_interface_during_load();
    int f;
    logic [ADDR_W-1:0] base, ea;
    seed = 8'($urandom);
    base = ADDR_W'($urandom);
    run_load(base, 1'b0, "iface", f);
    ea = base + ADDR_W'(14 * STRIDE + 14);
    checks++;
    if (addr_log[f + BLK_W * BLK_H - 1] !== ea) begin
      errors++;
      $display("FAIL iface last_addr: got %0d, required %0d", addr_log[f + BLK_W * BLK_H - 1], ea);
    end
    check_rows(base, "iface");
  endtask

  task automatic test_reset_mid_fetch();
    int f;
    logic [ADDR_W-1:0] base;
    base_addr = ADDR_W'($urandom);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (99) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset pre_busy: got %b, required 1", busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, interp_rst_n, mem_if.mem_rd_en} !== 4'b0000 || mem_if.mem_addr !== '0) begin
      errors++;
      $display("FAIL midreset outputs: busy/done/irst/rd_en=%b%b%b%b addr=%0d, required 0000 and 0",
               busy, done, interp_rst_n, mem_if.mem_rd_en, mem_if.mem_addr);
    end
    for (int r = 0; r <= BLK_H; r++) begin
      @(negedge clk);
      row_idx = 8'(r);
      #1;
      checks++;
      if (in_row !== '0) begin
        errors++;
        $display("FAIL midreset row%0d: got %h, required 0", r, in_row);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    seed = 8'($urandom);
    base = ADDR_W'($urandom);
    run_load(base, 1'b0, "after_reset", f);
    check_rows(base, "after_reset");
  endtask

  task automatic test_addr_wrap();
    int f;
    logic [ADDR_W-1:0] base;
    seed = 8'($urandom);
    base = ADDR_W'((1 << ADDR_W) - 5);
    run_load(base, 1'b0, "wrap", f);
    checks++;
    if (addr_log[f + 5] !== '0) begin
      errors++;
      $display("FAIL wrap sixth_addr: got %0d, required 0", addr_log[f + 5]);
    end
    check_rows(base, "wrap");
  endtask

  task automatic test_out_of_range();
    logic [ROW_W-1:0] e;
    logic [7:0] idx;
`ifdef ROW_EDGE_PAD_EN
    e = exp_row(BLK_H - 1, last_base);
`else
    e = '0;
`endif
    for (int k = 0; k < 4; k++) begin
      idx = (k == 0) ? 8'd15 : 8'($urandom_range(16, 255));
      @(negedge clk);
      row_idx = idx;
      #1;
      checks++;
      if (in_row !== e) begin
        errors++;
        $display("FAIL oob row_idx=%0d: got %h, required %h", idx, in_row, e);
      end
    end
  endtask

  task automatic test_restart_from_ready();
    int f;
    logic [ADDR_W-1:0] base;
    @(negedge clk); #1;
    checks++;
    if (interp_rst_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL restart in_ready: irst=%b busy=%b, required 1 and 0", interp_rst_n, busy);
    end
    seed = 8'($urandom);
    base = ADDR_W'($urandom);
    run_load(base, 1'b1, "restart", f);
    check_rows(base, "restart");
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_interface_during_load();
    test_reset_mid_fetch();
    test_addr_wrap();
    test_out_of_range();
    test_restart_from_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
